// File: rtl/bitwise_serial_lu.sv
// Multi-cycle bitwise logic unit: AND/OR/XOR/NOR over WIDTH bits, SLICE bits per clock.
// Optional registered parity output is enabled by defining LOGIC_PARITY_EN.
module bitwise_serial_lu #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             zero,
`ifdef LOGIC_PARITY_EN
    output logic             busy,
    output logic             parity
`else
    output logic             busy
`endif
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if ((WIDTH % SLICE) != 0) begin : g_bad_slice
            $error("bitwise_serial_lu: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic [1:0]        op_r;
    logic [CW-1:0]     cnt_r;
    logic [WIDTH-1:0]  res_r;
    logic              zero_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic              busy_r;
    logic [WIDTH-1:0]  lu_s;
    logic [WIDTH-1:0]  res_s;
    logic              accept_s;
    logic              last_s;
    logic              release_s;

    function automatic logic [WIDTH-1:0] logic_op(input logic [1:0] o,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] r;
        case (o)
            2'b00:   r = x & y;
            2'b01:   r = x | y;
            2'b10:   r = x ^ y;
            2'b11:   r = ~(x | y);
            default: r = '0;
        endcase
        return r;
    endfunction

    // Next-state decode and the result with the current slice merged in
    always_comb begin
        state_s   = state_r;
        accept_s  = 1'b0;
        last_s    = 1'b0;
        release_s = 1'b0;
        lu_s      = logic_op(op_r, a_r, b_r);
        res_s     = res_r;
        for (int i = 0; i < N; i++) begin
            if (cnt_r == CW'(i)) begin
                res_s[i*SLICE +: SLICE] = lu_s[i*SLICE +: SLICE];
            end else begin
                res_s[i*SLICE +: SLICE] = res_r[i*SLICE +: SLICE];
            end
        end
        case (state_r)
            S_IDLE: begin
                if (in_valid) begin
                    state_s  = S_BUSY;
                    accept_s = 1'b1;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_BUSY: begin
                if (cnt_r == CW'(N - 1)) begin
                    state_s = S_DONE;
                    last_s  = 1'b1;
                end else begin
                    state_s = S_BUSY;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_s   = S_IDLE;
                    release_s = 1'b1;
                end else begin
                    state_s = S_DONE;
                end
            end
            default: state_s = S_IDLE;
        endcase
    end

    // State register and registered handshake flags derived from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == S_IDLE);
            out_valid_r <= (state_s == S_DONE);
            busy_r      <= (state_s == S_BUSY);
        end
    end

    // Operand capture, slice-serial result build and zero flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r    <= '0;
            b_r    <= '0;
            op_r   <= 2'b00;
            cnt_r  <= '0;
            res_r  <= '0;
            zero_r <= 1'b0;
        end else if (accept_s) begin
            a_r    <= a;
            b_r    <= b;
            op_r   <= op;
            cnt_r  <= '0;
            res_r  <= '0;
            zero_r <= 1'b0;
        end else if (state_r == S_BUSY) begin
            res_r <= res_s;
            if (last_s) begin
                cnt_r  <= cnt_r;
                zero_r <= (res_s == '0);
            end else begin
                cnt_r  <= cnt_r + CW'(1);
                zero_r <= 1'b0;
            end
        end else if (release_s) begin
            zero_r <= 1'b0;
        end else begin
            zero_r <= zero_r;
        end
    end

`ifdef LOGIC_PARITY_EN
    logic parity_r;

    function automatic logic parity_of(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    // Parity of the final result, valid only while the result is presented
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_r <= 1'b0;
        end else if (accept_s || release_s) begin
            parity_r <= 1'b0;
        end else if (last_s) begin
            parity_r <= parity_of(res_s);
        end else begin
            parity_r <= parity_r;
        end
    end

    assign parity = parity_r;
`endif

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign res       = res_r;
    assign zero      = zero_r;

endmodule

// File: doc/bitwise_serial_lu.md
# bitwise_serial_lu

Parametrised, multi-cycle bitwise logic unit that evaluates AND/OR/XOR/NOR on two WIDTH-bit operands, SLICE bits per clock. It generalises the ALU's fixed 32-bit single-gate logic slices into one shared, width- and throughput-configurable unit. It sits behind the ALU operand registers and uses a valid/ready handshake on both sides, so the datapath can stall it.

## Interface
- WIDTH, 32, operand and result width in bits
- SLICE, 8, bits processed per cycle; WIDTH % SLICE == 0, otherwise elaboration error; N = WIDTH/SLICE
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous and active-low
- in_valid  in  1  operand request
- in_ready  out  1  unit can accept a request (high only in IDLE)
- op  in  2  00 AND, 01 OR, 10 XOR, 11 NOR
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- out_valid  out  1  res and zero are valid
- out_ready  in  1  consumer accepts the result
- res  out  WIDTH  result register
- zero  out  1  res == 0, qualified by out_valid
- busy  out  1  high in BUSY
- parity  out  1  XOR-reduction of res (present only with LOGIC_PARITY_EN)

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- IDLE: in_ready=1. When in_valid && in_ready, latch a, b and op into internal registers, clear res to 0, set slice counter cnt=0, and go to BUSY.
- BUSY: each cycle, res[cnt*SLICE +: SLICE] = op(a_q, b_q) over that slice, LSB slice first; then cnt++. The edge that writes slice N-1 moves the FSM to DONE. cnt is ceil(log2(N)) bits wide (minimum 1) and never wraps past N-1.
- DONE: out_valid=1; res, zero and parity are held stable. When out_ready=1, go to IDLE.
- Inputs a, b, op and in_valid are ignored outside the IDLE acceptance edge. Operand changes during BUSY have no effect.
- zero and parity are computed from the final res. Both are 0 when out_valid=0.
- Reset at any time, including mid-operation, aborts immediately. The result is discarded, and there is no partial output.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, res=0, zero=0, parity=0.
- Acceptance edge E0. Slices are written at edges E1..EN. out_valid rises after EN. Latency is N cycles from acceptance to out_valid.
- SLICE == WIDTH gives N=1: one BUSY cycle, then DONE.
- Output handshake completes on the edge with out_valid && out_ready. in_ready rises the cycle after that edge.
- No overlap: minimum request-to-request spacing is N+2 cycles with out_ready held high.
- out_ready low in DONE: stay in DONE indefinitely with all outputs stable.
- Simultaneous in_valid during DONE or BUSY: not accepted, because in_ready=0. The requester must hold in_valid.

## Configuration
- LOGIC_PARITY_EN defined: the parity port exists, driven by a register updated on the edge that enters DONE, equal to ^res, and cleared on acceptance and reset.
- LOGIC_PARITY_EN undefined: the parity port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset: assert rst_n=0 mid-BUSY -> out_valid=0, res=0, in_ready=1 immediately; no out_valid pulse after release.
- XOR: WIDTH=32, SLICE=8, op=10, a=0xFFFF0000, b=0x0F0F0F0F -> out_valid exactly 4 cycles after acceptance, res=0xF0F00F0F, zero=0, parity=0 (with LOGIC_PARITY_EN).
- AND/zero: op=00, a=0x12345678, b=0x00000000 -> res=0x00000000, zero=1. Follow with NOR, a=b=0 -> res=0xFFFFFFFF, zero=0.
- Backpressure: OR, a=0x00000001, b=0x80000000, with out_ready=0 for 10 cycles -> out_valid and res=0x80000001 stable and in_ready=0 throughout; in_ready=1 one cycle after out_ready=1.
- Operand change: after acceptance (XOR, a=0xAAAAAAAA, b=0x55555555), drive a=0, b=0, op=00 during BUSY -> res=0xFFFFFFFF; in_valid during BUSY is not accepted.
- Parameters: WIDTH=16, SLICE=16, op=10, a=0x00FF, b=0x0F0F -> res=0x0FF0 after 1 cycle; parity=0 (with LOGIC_PARITY_EN).
